// File: rtl/jk_bank_pkg.sv
// Shared definitions for the JK bank arbiter: command encodings, FSM states
// and the per-bit JK next-state function.
package jk_bank_pkg;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  // Widest bank jk_next supports; callers cast down to their own width.
  localparam int JK_MAX_W = 64;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  function automatic logic [JK_MAX_W-1:0] jk_next(input logic [JK_MAX_W-1:0] q,
                                                  input logic [JK_MAX_W-1:0] j,
                                                  input logic [JK_MAX_W-1:0] k);
    logic [JK_MAX_W-1:0] n;
    n = q;
    for (int b = 0; b < JK_MAX_W; b++) begin
      case ({j[b], k[b]})
        JK_HOLD: n[b] = q[b];
        JK_CLR:  n[b] = 1'b0;
        JK_SET:  n[b] = 1'b1;
        default: n[b] = ~q[b];
      endcase
    end
    return n;
  endfunction

endpackage

// File: rtl/jk_bank_arbiter_jk_reg_bank.sv
// WIDTH-bit JK register bank with load enable; Q and Q_bar are both
// registered from one next-state value so they can never disagree.
module jk_reg_bank
  import jk_bank_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] j_i,
  input  logic [WIDTH-1:0] k_i,
  output logic [WIDTH-1:0] q_o,
  output logic [WIDTH-1:0] q_bar_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_bar_q;
  logic [WIDTH-1:0] q_d;

  assign q_d = load_i ? WIDTH'(jk_next(JK_MAX_W'(q_q), JK_MAX_W'(j_i), JK_MAX_W'(k_i)))
                      : q_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q     <= '0;
      q_bar_q <= '1;
    end else begin
      q_q     <= q_d;
      q_bar_q <= ~q_d;
    end
  end

  assign q_o     = q_q;
  assign q_bar_o = q_bar_q;

endmodule

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter sharing one JK register bank between NREQ requesters,
// with a bounded lock mode for atomic multi-command sequences.
module jk_bank_arbiter
  import jk_bank_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int LOCK_MAX = 16,
  localparam int IDW     = $clog2(NREQ),
  localparam int CW      = $clog2(LOCK_MAX + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NREQ-1:0]       req_valid_i,
  output logic [NREQ-1:0]       req_ready_o,
  input  logic [NREQ-1:0]       req_lock_i,
  input  logic [NREQ*WIDTH-1:0] req_j_i,
  input  logic [NREQ*WIDTH-1:0] req_k_i,
  output logic [WIDTH-1:0]      q_o,
  output logic [WIDTH-1:0]      q_bar_o,
  output logic [IDW-1:0]        grant_id_o,
  output logic                  locked_o
);

  arb_state_e       state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic [CW-1:0]    lcnt_q, lcnt_d;
  logic [NREQ-1:0]  ready;
  logic [IDW-1:0]   grant;
  logic             found;
  int               cand;
  logic [WIDTH-1:0] j_lane [NREQ];
  logic [WIDTH-1:0] k_lane [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_lane
      assign j_lane[gi] = req_j_i[gi*WIDTH +: WIDTH];
      assign k_lane[gi] = req_k_i[gi*WIDTH +: WIDTH];
    end
  endgenerate

  function automatic logic [IDW-1:0] ptr_after(input logic [IDW-1:0] i);
    return (int'(i) == NREQ - 1) ? '0 : i + 1'b1;
  endfunction

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    lcnt_d  = lcnt_q;
    ready   = '0;
    grant   = '0;
    found   = 1'b0;
    cand    = 0;
    case (state_q)
      ARB: begin
        for (int off = 0; off < NREQ; off++) begin
          cand = int'(ptr_q) + off;
          if (cand >= NREQ) cand = cand - NREQ;
          if (!found && req_valid_i[cand]) begin
            found = 1'b1;
            grant = IDW'(cand);
          end
        end
        if (found) begin
          ready[grant] = 1'b1;
          if (req_lock_i[grant]) begin
            state_d = LOCKED;
            owner_d = grant;
            lcnt_d  = CW'(1);
          end else begin
            ptr_d = ptr_after(grant);
          end
        end
      end
      LOCKED: begin
        lcnt_d = lcnt_q + 1'b1;
        if (req_valid_i[owner_q]) begin
          ready[owner_q] = 1'b1;
          grant          = owner_q;
        end
        // A lock request on the timeout edge is ignored: the window is hard.
        if ((req_valid_i[owner_q] && !req_lock_i[owner_q]) || lcnt_q == CW'(LOCK_MAX)) begin
          state_d = ARB;
          ptr_d   = ptr_after(owner_q);
          lcnt_d  = '0;
        end
      end
      default: state_d = ARB;
    endcase
    if (rst_i) begin
      ready = '0;
      grant = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB;
      ptr_q   <= '0;
      owner_q <= '0;
      lcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      lcnt_q  <= lcnt_d;
    end
  end

  jk_reg_bank #(
    .WIDTH(WIDTH)
  ) u_bank (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (|ready),
    .j_i    (j_lane[grant]),
    .k_i    (k_lane[grant]),
    .q_o    (q_o),
    .q_bar_o(q_bar_o)
  );

  assign req_ready_o = ready;
  assign grant_id_o  = grant;
  assign locked_o    = (state_q == LOCKED);

endmodule
